// File: rtl/comm_master.sv
// Host-side command initiator: sends a 16-bit command as two 8N1 frames
// (high byte first), then captures the single response byte.
module comm_master #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic        TX,
  output logic        cmd_cmplt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    TX_HIGH,
    TX_LOW,
    WAIT_RESP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t      state;
  logic [9:0]  shifter;
  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  low_byte;
  logic        baud_done;
  logic        frame_done;

  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign frame_done = baud_done && (bit_cnt == 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shifter    <= 10'h3ff;
      baud_cnt   <= 16'd0;
      bit_cnt    <= 4'd0;
      low_byte   <= 8'h00;
      TX         <= 1'b1;
      busy       <= 1'b0;
      cmd_cmplt  <= 1'b0;
      clr_rx_rdy <= 1'b0;
      resp_rdy   <= 1'b0;
      resp       <= 8'h00;
    end else begin
      cmd_cmplt  <= 1'b0;
      clr_rx_rdy <= 1'b0;
      unique case (state)
        IDLE: begin
          if (snd_cmd) begin
            low_byte   <= cmd[7:0];
            shifter    <= {1'b1, cmd[15:8], 1'b0};
            TX         <= 1'b0;
            baud_cnt   <= 16'd0;
            bit_cnt    <= 4'd0;
            resp_rdy   <= 1'b0;
            clr_rx_rdy <= 1'b1;
            busy       <= 1'b1;
            state      <= TX_HIGH;
          end
        end
        TX_HIGH, TX_LOW: begin
          if (!baud_done) begin
            baud_cnt <= baud_cnt + 16'd1;
          end else begin
            baud_cnt <= 16'd0;
            if (!frame_done) begin
              shifter <= {1'b1, shifter[9:1]};
              TX      <= shifter[1];
              bit_cnt <= bit_cnt + 4'd1;
            end else if (state == TX_HIGH) begin
              // Back-to-back frames: low start bit follows the stop bit
              shifter <= {1'b1, low_byte, 1'b0};
              TX      <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= TX_LOW;
            end else begin
              TX        <= 1'b1;
              bit_cnt   <= 4'd0;
              cmd_cmplt <= 1'b1;
              state     <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (rx_rdy) begin
            resp       <= rx_data;
            resp_rdy   <= 1'b1;
            clr_rx_rdy <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          TX    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
